// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller for the stack processor. It sequences the fetch address
// through start/halt, stall, relative branch, absolute jump and call/return.
// Call/return uses a small return-address stack (RAS).
//
// Parameters
//   PC_W        program counter width (instruction memory is 2^PC_W words)
//   RAS_DEPTH   number of return-address stack entries
//   START_ADDR  PC value after reset and on every start
//
// Ports
//   clk         single clock, all state changes on posedge
//   reset_n     asynchronous active-low reset
//   start       begin execution (honoured in IDLE or HALTED only)
//   stall       freeze PC, RAS, flags and state for this cycle (RUN only)
//   halt_en     halt request
//   ret_en      pop the RAS into PC
//   call_en     push PC+1 and jump to jump_addr
//   jump_en     absolute jump to jump_addr
//   jump_addr   target for jump and call
//   branch_en   relative branch taken
//   branch_off  signed 8-bit branch offset
//   PC          current program count (registered)
//   running     high while in RUN (decoded from the state register)
//   done        high while in HALTED (decoded from the state register)
//   ras_ovf     sticky: a call was made with the RAS full
//   ras_unf     sticky: a return was made with the RAS empty
module pc_sequencer #(
    parameter int PC_W       = 9,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            halt_en,
    input  logic            ret_en,
    input  logic            call_en,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            branch_en,
    input  logic [7:0]      branch_off,
    output logic [PC_W-1:0] PC,
    output logic            running,
    output logic            done,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   ras_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_r;
    logic              ovf_r;
    logic              unf_r;

    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   branch_tgt_s;
    logic [PC_W-1:0]   ras_top_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic [IDX_W-1:0]  push_idx_s;
    logic              ras_full_s;
    logic              ras_empty_s;

    // Sign-extend the 8-bit branch offset to PC width; the add then wraps naturally.
    function automatic logic [PC_W-1:0] sext_off(input logic [7:0] off);
        return PC_W'($signed(off));
    endfunction

    // Candidate next-PC values and RAS occupancy decode.
    always_comb begin
        pc_inc_s     = pc_r + PC_ONE;
        branch_tgt_s = pc_r + sext_off(branch_off);
        ras_full_s   = (ras_ptr_r == PTR_FULL);
        ras_empty_s  = (ras_ptr_r == PTR_ZERO);
        top_idx_s    = IDX_W'(ras_ptr_r - PTR_ONE);
        push_idx_s   = IDX_W'(ras_ptr_r);
        ras_top_s    = ras_r[top_idx_s];
    end

    // Sequencer FSM: state, PC, RAS and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= START_PC;
            ras_ptr_r <= PTR_ZERO;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= {PC_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pc_r <= START_PC;
                    if (start) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A stall freezes everything, so all actions sit under !stall.
                    if (!stall) begin
                        if (halt_en) begin
                            state_r <= ST_HALTED;
                        end else if (ret_en) begin
                            if (!ras_empty_s) begin
                                pc_r      <= ras_top_s;
                                ras_ptr_r <= ras_ptr_r - PTR_ONE;
                            end else begin
                                unf_r <= 1'b1;
                                pc_r  <= pc_inc_s;
                            end
                        end else if (call_en) begin
                            // The jump happens even when the push is lost.
                            if (!ras_full_s) begin
                                ras_r[push_idx_s] <= pc_inc_s;
                                ras_ptr_r         <= ras_ptr_r + PTR_ONE;
                            end else begin
                                ovf_r <= 1'b1;
                            end
                            pc_r <= jump_addr;
                        end else if (jump_en) begin
                            pc_r <= jump_addr;
                        end else if (branch_en) begin
                            pc_r <= branch_tgt_s;
                        end else begin
                            pc_r <= pc_inc_s;
                        end
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_HALTED: begin
                    // Restart is a clean slate: empty RAS and cleared flags.
                    if (start) begin
                        state_r   <= ST_RUN;
                        pc_r      <= START_PC;
                        ras_ptr_r <= PTR_ZERO;
                        ovf_r     <= 1'b0;
                        unf_r     <= 1'b0;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pc_r    <= START_PC;
                end
            endcase
        end
    end

    assign PC      = pc_r;
    assign running = (state_r == ST_RUN);
    assign done    = (state_r == ST_HALTED);
    assign ras_ovf = ovf_r;
    assign ras_unf = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (PC_W=9, RAS_DEPTH=4, START_ADDR=0).
module tb_pc_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       stall;
    logic       halt_en;
    logic       ret_en;
    logic       call_en;
    logic       jump_en;
    logic [8:0] jump_addr;
    logic       branch_en;
    logic [7:0] branch_off;
    logic [8:0] PC;
    logic       running;
    logic       done;
    logic       ras_ovf;
    logic       ras_unf;

    int n_cmp;
    int n_err;

    pc_sequencer #(
        .PC_W(9),
        .RAS_DEPTH(4),
        .START_ADDR(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .stall(stall),
        .halt_en(halt_en),
        .ret_en(ret_en),
        .call_en(call_en),
        .jump_en(jump_en),
        .jump_addr(jump_addr),
        .branch_en(branch_en),
        .branch_off(branch_off),
        .PC(PC),
        .running(running),
        .done(done),
        .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, sl, h, r, c, j;
        logic [8:0] ja;
        logic       b;
        logic [7:0] bo;
        logic [8:0] epc;
        logic       erun, edone, eovf, eunf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic sl, input logic h, input logic r,
                                input logic c, input logic j, input logic [8:0] ja,
                                input logic b, input logic [7:0] bo, input logic [8:0] epc,
                                input logic erun, input logic edone, input logic eovf,
                                input logic eunf);
        vec_t v;
        v.st = st; v.sl = sl; v.h = h; v.r = r; v.c = c; v.j = j; v.ja = ja;
        v.b = b; v.bo = bo; v.epc = epc; v.erun = erun; v.edone = edone;
        v.eovf = eovf; v.eunf = eunf;
        return v;
    endfunction

    task automatic drive(input logic st, input logic sl, input logic h, input logic r,
                         input logic c, input logic j, input logic [8:0] ja,
                         input logic b, input logic [7:0] bo);
        start = st; stall = sl; halt_en = h; ret_en = r; call_en = c;
        jump_en = j; jump_addr = ja; branch_en = b; branch_off = bo;
    endtask

    task automatic chk(input string name, input logic [8:0] epc, input logic erun,
                       input logic edone, input logic eovf, input logic eunf);
        n_cmp++;
        if ({PC, running, done, ras_ovf, ras_unf} !== {epc, erun, edone, eovf, eunf}) begin
            n_err++;
            $display("FAIL %s: got pc=%0d run=%b done=%b ovf=%b unf=%b, want pc=%0d run=%b done=%b ovf=%b unf=%b",
                     name, PC, running, done, ras_ovf, ras_unf, epc, erun, edone, eovf, eunf);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 8'd0);

        //            st   sl   h    r    c    j    ja      b    bo       epc     run  done ovf  unf
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd0,  1'b1,1'b0,1'b0,1'b0)); // start
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd1,  1'b1,1'b0,1'b0,1'b0)); // start ignored in RUN
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd2,  1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'd10, 1'b0,8'h00, 9'd10, 1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b1,8'hFC, 9'd6,  1'b1,1'b0,1'b0,1'b0)); // -4
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b1,8'h7F, 9'd133,1'b1,1'b0,1'b0,1'b0)); // +127
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'd0,  1'b0,8'h00, 9'd0,  1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b1,8'hFF, 9'd511,1'b1,1'b0,1'b0,1'b0)); // -1 wraps
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd0,  1'b1,1'b0,1'b0,1'b0)); // 511 -> 0
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'd20, 1'b0,8'h00, 9'd20, 1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd100,1'b0,8'h00, 9'd100,1'b1,1'b0,1'b0,1'b0)); // call, push 21
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd101,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd102,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd21, 1'b1,1'b0,1'b0,1'b0)); // ret
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd200,1'b0,8'h00, 9'd200,1'b1,1'b0,1'b0,1'b0)); // push 22
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd300,1'b0,8'h00, 9'd300,1'b1,1'b0,1'b0,1'b0)); // push 201
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd400,1'b0,8'h00, 9'd400,1'b1,1'b0,1'b0,1'b0)); // push 301
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd500,1'b0,8'h00, 9'd500,1'b1,1'b0,1'b0,1'b0)); // push 401, full
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd50, 1'b0,8'h00, 9'd50, 1'b1,1'b0,1'b1,1'b0)); // overflow
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd401,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd301,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd201,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd22, 1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd23, 1'b1,1'b0,1'b1,1'b1)); // underflow
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'd50, 1'b0,8'h00, 9'd50, 1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,9'd200,1'b0,8'h00, 9'd50, 1'b1,1'b0,1'b1,1'b1)); // stall
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,9'd200,1'b0,8'h00, 9'd50, 1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,9'd200,1'b1,8'h05, 9'd50, 1'b1,1'b0,1'b1,1'b1)); // stall beats all
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'd200,1'b0,8'h00, 9'd200,1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,9'd511,1'b0,8'h00, 9'd511,1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd7,  1'b0,8'h00, 9'd7,  1'b1,1'b0,1'b1,1'b1)); // push wraps to 0
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd0,  1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,9'd30, 1'b0,8'h00, 9'd30, 1'b1,1'b0,1'b1,1'b1)); // push 1
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd30, 1'b0,1'b1,1'b1,1'b1)); // halt wins
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,9'd99, 1'b1,8'h0A, 9'd30, 1'b0,1'b1,1'b1,1'b1)); // ignored
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd0,  1'b1,1'b0,1'b0,1'b0)); // restart
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd1,  1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,9'd0,  1'b0,8'h00, 9'd2,  1'b1,1'b0,1'b0,1'b1)); // RAS was emptied

        // Reset state, then release on a negedge.
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // IDLE ignores everything except start.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd77, 1'b1, 8'h10);
        @(negedge clk);
        chk("idle_ignores", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].sl, vecs[i].h, vecs[i].r, vecs[i].c, vecs[i].j,
                  vecs[i].ja, vecs[i].b, vecs[i].bo);
            @(negedge clk);
            chk($sformatf("vec%0d", i), vecs[i].epc, vecs[i].erun, vecs[i].edone,
                vecs[i].eovf, vecs[i].eunf);
        end

        // Asynchronous reset mid-RUN acts without a clock edge.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 8'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Free run: 0..511, wrap, 0,1,2.
        for (int i = 0; i < 515; i++) begin
            drive((i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 8'd0);
            @(negedge clk);
            chk($sformatf("freerun%0d", i), 9'(i % 512), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the stack processor: it replaces the free-running fetch counter with a sequenced one that supports start/halt, stall, relative branch, absolute jump, and call/return through a small return-address stack (RAS). It sits between the decode/control logic, which drives the request strobes, and instruction memory, which is addressed by `PC`. All outputs are registered or decoded directly from state registers.

## Interface
- `PC_W`, 9: PC width; instruction memory is 2^PC_W words.
- `RAS_DEPTH`, 4: return-address stack entries.
- `START_ADDR`, 0: PC value on reset and on every start.

- `clk`  in  1  single clock; all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution; honoured in IDLE or HALTED only.
- `stall`  in  1  freeze the PC and all state for this cycle (RUN only).
- `halt_en`  in  1  halt request.
- `ret_en`  in  1  return: pop RAS into PC.
- `call_en`  in  1  call: push PC+1, jump to `jump_addr`.
- `jump_en`  in  1  absolute jump to `jump_addr`.
- `jump_addr`  in  PC_W  target for jump and call.
- `branch_en`  in  1  relative branch taken.
- `branch_off`  in  8  signed two's-complement branch offset.
- `PC`  out  PC_W  current program count.
- `running`  out  1  high while state is RUN.
- `done`  out  1  high while state is HALTED.
- `ras_ovf`  out  1  sticky flag: a call was made while the RAS was full.
- `ras_unf`  out  1  sticky flag: a return was made while the RAS was empty.

## Operation
- States are IDLE, RUN, and HALTED.
- Reset (asynchronous, `reset_n`=0) clears the block to:
  - state IDLE, `PC`=START_ADDR;
  - RAS empty, `ras_ovf`=`ras_unf`=0;
  - `running`=0, `done`=0.
- IDLE:
  - `PC` holds START_ADDR.
  - `start` moves to RUN; `PC` stays START_ADDR on the transition.
  - All other inputs are ignored.
- RUN: with `stall`=0, exactly one action is taken per cycle, in this priority order:
  1. `halt_en`: go to HALTED, `PC` holds.
  2. `ret_en`:
     - RAS non-empty: pop, `PC` <= popped value.
     - RAS empty: set `ras_unf`, `PC` <= PC+1.
  3. `call_en`:
     - RAS not full: push PC+1, `PC` <= `jump_addr`.
     - RAS full: set `ras_ovf`, discard the push, still `PC` <= `jump_addr`.
  4. `jump_en`: `PC` <= `jump_addr`.
  5. `branch_en`: `PC` <= PC + sign_extend(`branch_off`), modulo 2^PC_W.
  6. None of the above: `PC` <= PC+1, modulo 2^PC_W (511 wraps to 0).
- RUN with `stall`=1: no change to PC, RAS, flags, or state, regardless of any other input.
- `start` during RUN is ignored.
- HALTED:
  - `PC` holds.
  - `start` returns to RUN with `PC`=START_ADDR, RAS emptied, and both sticky flags cleared.
  - All other inputs are ignored.
- Pushed return addresses also wrap modulo 2^PC_W: a call at PC=511 pushes 0.
- RAS is LIFO; its pointer never exceeds RAS_DEPTH and never goes below 0.

## Timing
- Control inputs are sampled at posedge `clk`; their effect appears on `PC` and flags one cycle later. There is no combinational input-to-output path.
- `running` and `done` are decoded from the state register and change in the same cycle as the state.
- `start` is a level input sampled each cycle; holding it high across several cycles gives the same result as a single-cycle pulse.
- Reset asserted mid-RUN forces IDLE and `PC`=START_ADDR immediately; reset deassertion takes effect at the next posedge.
- A call immediately followed by a return, with no stall, restores PC+1 of the call site two cycles after the call was sampled.

## Test plan
- Reset then `start`, no other requests, for 515 cycles:
  - `PC` runs 0,1,…,511,0,1,2.
  - `running`=1 throughout, `done`=0.
- At PC=10, `branch_en` with `branch_off`=-4: next PC=6. At PC=6, `branch_off`=+127: next PC=133. At PC=0, `branch_off`=-1: next PC=511.
- At PC=20, `call_en` with `jump_addr`=100; run to PC=102; then `ret_en`:
  - `PC` sequence is 20,100,101,102,21.
  - No flags set.
- Five nested calls with RAS_DEPTH=4:
  - `ras_ovf`=1 after the fifth call, which still jumps.
  - Four returns unwind correctly.
  - A fifth return sets `ras_unf` and gives PC+1.
- At PC=50, assert `stall` together with `jump_en` for 3 cycles: PC stays 50. Then drop `stall`, keeping `jump_en`=1 with `jump_addr`=200: PC=200.
- At PC=30, assert `halt_en` and `ret_en` together:
  - Halt wins: `done`=1, `PC`=30 held.
  - `start` then gives `PC`=0, `done`=0, flags cleared.
  - Separately, pulling `reset_n` low mid-RUN gives IDLE and `PC`=0 with no clock edge needed.
